// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch controller: debounced start/lap buttons, run/lap/pause FSM,
// BCD seconds/minutes counter and registered seven-segment digit scheduling.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_BITS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       sec_clk,
    input  logic [1:0] scan_ctl,
    output logic       div_clr,
    output logic [3:0] bcd_out,
    output logic [3:0] ssd_en,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_CYCLES - 1);

    // Index 0 = start button, index 1 = lap button
    logic [1:0]         w_btn;
    logic [1:0]         r_sync1, r_sync2, r_db_lvl, r_pls;
    logic [DB_BITS-1:0] r_db_cnt [2];

    logic        r_sec_d;
    logic        w_tick, w_s, w_l;
    state_t      r_state, w_next;
    logic        w_div_clr, w_latch, w_clear, w_count_en, w_at_max;
    logic [3:0]  r_s1, r_s10, r_m1, r_m10;
    logic [15:0] r_lat, w_live, w_src;
    logic        r_div_clr, r_running, r_rollover;
    logic [3:0]  r_bcd, r_en;

    assign w_btn = {btn_lap, btn_start};
    assign w_s   = r_pls[0];
    assign w_l   = r_pls[1];

    // Counter only advances while the synchronised level differs from the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db_lvl <= '0;
            r_pls    <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_pls[i] <= 1'b0;
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_db_lvl[i] <= r_sync2[i];
                    r_pls[i]    <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_sec_d <= 1'b0;
        else     r_sec_d <= sec_clk;
    end

    assign w_tick = sec_clk & ~r_sec_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div_clr <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_div_clr <= w_div_clr;
            r_running <= (w_next == RUN) || (w_next == LAP);
        end
    end

    // Start has priority: when both pulses coincide the lap pulse is dropped
    always_comb begin
        w_next    = r_state;
        w_div_clr = 1'b0;
        w_latch   = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_next    = RUN;
                    w_div_clr = 1'b1;
                end
            end
            RUN: begin
                if (w_s) begin
                    w_next = PAUSE;
                end else if (w_l) begin
                    w_next  = LAP;
                    w_latch = 1'b1;
                end
            end
            LAP: begin
                if (w_s)      w_next = PAUSE;
                else if (w_l) w_next = RUN;
            end
            PAUSE: begin
                if (w_s) begin
                    w_next    = RUN;
                    w_div_clr = 1'b1;
                end else if (w_l) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_count_en = w_tick && !w_s && ((r_state == RUN) || (r_state == LAP));
    assign w_at_max   = (r_s1 == 4'd9) && (r_s10 == 4'd5) && (r_m1 == 4'd9) && (r_m10 == 4'd5);
    assign w_live     = {r_m10, r_m1, r_s10, r_s1};

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_s1  <= '0;
            r_s10 <= '0;
            r_m1  <= '0;
            r_m10 <= '0;
        end else if (w_count_en) begin
            if (r_s1 != 4'd9) begin
                r_s1 <= r_s1 + 4'd1;
            end else begin
                r_s1 <= '0;
                if (r_s10 != 4'd5) begin
                    r_s10 <= r_s10 + 4'd1;
                end else begin
                    r_s10 <= '0;
                    if (r_m1 != 4'd9) begin
                        r_m1 <= r_m1 + 4'd1;
                    end else begin
                        r_m1  <= '0;
                        r_m10 <= (r_m10 == 4'd5) ? 4'd0 : r_m10 + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat      <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_count_en && w_at_max;
            if (w_latch) r_lat <= w_live;
        end
    end

    assign w_src = (r_state == LAP) ? r_lat : w_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_en  <= 4'b1111;
        end else begin
            case (scan_ctl)
                2'd0:    r_bcd <= w_src[3:0];
                2'd1:    r_bcd <= w_src[7:4];
                2'd2:    r_bcd <= w_src[11:8];
                default: r_bcd <= w_src[15:12];
            endcase
            r_en <= ~(4'b0001 << scan_ctl);
        end
    end

    assign div_clr  = r_div_clr;
    assign running  = r_running;
    assign rollover = r_rollover;
    assign bcd_out  = r_bcd;
    assign ssd_en   = r_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       sec_clk = 1'b0;
    logic [1:0] scan_ctl = 2'd0;
    logic       div_clr;
    logic [3:0] bcd_out;
    logic [3:0] ssd_en;
    logic       running;
    logic       rollover;

    int total = 0;
    int bad = 0;
    int n_divclr = 0;
    int n_roll = 0;
    int d0;
    int r0;
    logic [15:0] disp;

    stopwatch_ctrl #(.DB_CYCLES(4), .DB_BITS(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
        .sec_clk(sec_clk), .scan_ctl(scan_ctl), .div_clr(div_clr),
        .bcd_out(bcd_out), .ssd_en(ssd_en), .running(running), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and tally single-cycle pulses
    task automatic cyc();
        @(posedge clk);
        #1;
        if (div_clr === 1'b1) n_divclr++;
        if (rollover === 1'b1) n_roll++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            sec_clk = 1'b1;
            cyc();
            sec_clk = 1'b0;
            cyc();
        end
    endtask

    task automatic press(input logic s, input logic l);
        btn_start = s;
        btn_lap   = l;
        repeat (20) cyc();
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic read_disp(output logic [15:0] v);
        logic [3:0] exp_en;
        v = '0;
        for (int d = 0; d < 4; d++) begin
            scan_ctl = 2'(d);
            cyc();
            v[4*d +: 4] = bcd_out;
            exp_en = ~(4'b0001 << d);
            chk("ssd_en_scan", {12'd0, ssd_en}, {12'd0, exp_en});
        end
        scan_ctl = 2'd0;
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_en", {12'd0, ssd_en}, 16'h000f);
        chk("rst_bcd", {12'd0, bcd_out}, 16'h0000);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_divclr", {15'd0, div_clr}, 16'd0);
        chk("rst_rollover", {15'd0, rollover}, 16'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_en", {12'd0, ssd_en}, 16'h000e);

        // Debounce: 3-cycle glitch rejected, long hold gives one div_clr pulse
        d0 = n_divclr;
        btn_start = 1'b1;
        repeat (3) cyc();
        btn_start = 1'b0;
        repeat (12) cyc();
        chk("glitch_divclr", 16'(n_divclr - d0), 16'd0);
        chk("glitch_running", {15'd0, running}, 16'd0);
        d0 = n_divclr;
        press(1'b1, 1'b0);
        chk("start_divclr", 16'(n_divclr - d0), 16'd1);
        chk("start_running", {15'd0, running}, 16'd1);

        // Count
        tick(75);
        read_disp(disp);
        chk("count_0115", disp, 16'h0115);

        // Wrap
        r0 = n_roll;
        tick(3524);
        read_disp(disp);
        chk("pre_wrap_5959", disp, 16'h5959);
        chk("pre_wrap_roll", 16'(n_roll - r0), 16'd0);
        tick(1);
        chk("wrap_roll_once", 16'(n_roll - r0), 16'd1);
        read_disp(disp);
        chk("wrap_0000", disp, 16'h0000);
        chk("wrap_running", {15'd0, running}, 16'd1);

        // Lap freeze and release
        tick(10);
        press(1'b0, 1'b1);
        chk("lap_running", {15'd0, running}, 16'd1);
        tick(5);
        read_disp(disp);
        chk("lap_frozen", disp, 16'h0010);
        press(1'b0, 1'b1);
        read_disp(disp);
        chk("lap_live", disp, 16'h0015);
        chk("lap_back_running", {15'd0, running}, 16'd1);

        // Reset while running at 12:34
        tick(739);
        read_disp(disp);
        chk("pre_rst_1234", disp, 16'h1234);
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst2_en", {12'd0, ssd_en}, 16'h000f);
        chk("rst2_bcd", {12'd0, bcd_out}, 16'h0000);
        chk("rst2_running", {15'd0, running}, 16'd0);
        rst = 1'b0;
        cyc();
        chk("rst2_post_en", {12'd0, ssd_en}, 16'h000e);
        read_disp(disp);
        chk("rst2_0000", disp, 16'h0000);

        // IDLE ignores lap
        d0 = n_divclr;
        press(1'b0, 1'b1);
        chk("idle_lap_running", {15'd0, running}, 16'd0);
        chk("idle_lap_divclr", 16'(n_divclr - d0), 16'd0);

        // Pause holds the count, lap from pause clears
        press(1'b1, 1'b0);
        chk("restart_divclr", 16'(n_divclr - d0), 16'd1);
        tick(2);
        d0 = n_divclr;
        press(1'b1, 1'b0);
        chk("pause_running", {15'd0, running}, 16'd0);
        chk("pause_divclr", 16'(n_divclr - d0), 16'd0);
        tick(3);
        read_disp(disp);
        chk("pause_hold", disp, 16'h0002);
        press(1'b0, 1'b1);
        chk("clear_running", {15'd0, running}, 16'd0);
        read_disp(disp);
        chk("clear_0000", disp, 16'h0000);

        // Start and lap together from PAUSE: start wins
        press(1'b1, 1'b0);
        tick(2);
        press(1'b1, 1'b0);
        chk("pause2_running", {15'd0, running}, 16'd0);
        d0 = n_divclr;
        press(1'b1, 1'b1);
        chk("both_divclr", 16'(n_divclr - d0), 16'd1);
        chk("both_running", {15'd0, running}, 16'd1);
        read_disp(disp);
        chk("both_not_cleared", disp, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
